// File: rtl/lau_pkg.sv
// Shared arithmetic-unit package.
// Provides the speed selector used by the arithmetic building blocks:
//   SLOW - bit-serial ripple structure
//   FAST - single-expression arithmetic, left to the synthesis tool
package lau_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

endpackage

// File: rtl/DecC.sv
// Decrementer with carry-in: S = A - CI, CO = borrow out of the MSB.
// Ports:
//   A  [width-1:0] in  - operand
//   CI             in  - amount to subtract (0 or 1)
//   S  [width-1:0] out - result
//   CO             out - borrow out (A == 0 && CI == 1)
module DecC
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic             CI,
    output logic [width-1:0] S,
    output logic             CO
);

    generate
        if (speed == FAST) begin : g_fast
            logic [width:0] diff;
            // The extra MSB of the widened subtraction is the borrow.
            assign diff = {1'b0, A} - {{width{1'b0}}, CI};
            assign S    = diff[width-1:0];
            assign CO   = diff[width];
        end else begin : g_ripple
            logic [width:0] borrow;
            assign borrow[0] = CI;
            for (genvar gi = 0; gi < width; gi++) begin : g_bit
                assign S[gi]          = A[gi] ^ borrow[gi];
                assign borrow[gi + 1] = ~A[gi] & borrow[gi];
            end
            assign CO = borrow[width];
        end
    endgenerate

endmodule

// File: rtl/behavioural_dec_timer.sv
// Behavioural reference of dec_timer for equivalence checking: same ports
// and timing, decrement written directly as Q-1 instead of through DecC.
// Ports: identical to dec_timer.
module behavioural_dec_timer
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = lau_pkg::FAST
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_VAL,
    output logic             LD_RDY,
    input  logic [width-1:0] LD_DATA,
    input  logic             EN,
    input  logic             RELOAD,
    input  logic             ABORT,
    output logic [width-1:0] Q,
    output logic             BUSY,
    output logic             TC
);

    logic             busy_q, busy_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] rv_q, rv_d;
    logic             tc_q, tc_d;
    logic [width-1:0] q_minus_one;

    // Two spellings of Q-1, one per speed setting, both plain arithmetic.
    generate
        if (speed == FAST) begin : g_sub
            assign q_minus_one = q_q - {{(width - 1){1'b0}}, 1'b1};
        end else begin : g_add
            assign q_minus_one = q_q + {width{1'b1}};
        end
    endgenerate

    always_comb begin
        busy_d = busy_q;
        q_d    = q_q;
        rv_d   = rv_q;
        tc_d   = 1'b0;
        if (!busy_q) begin
            if (LD_VAL) begin
                q_d    = LD_DATA;
                rv_d   = LD_DATA;
                tc_d   = (LD_DATA == '0);
                busy_d = (LD_DATA != '0);
            end
        end else if (ABORT) begin
            busy_d = 1'b0;
        end else if (EN) begin
            if (q_minus_one == '0) begin
                tc_d   = 1'b1;
                q_d    = RELOAD ? rv_q : '0;
                busy_d = RELOAD;
            end else begin
                q_d = q_minus_one;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= 1'b0;
            q_q    <= '0;
            rv_q   <= '0;
            tc_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            q_q    <= q_d;
            rv_q   <= rv_d;
            tc_q   <= tc_d;
        end
    end

    assign Q      = q_q;
    assign TC     = tc_q;
    assign BUSY   = busy_q;
    assign LD_RDY = ~busy_q;

endmodule

// File: rtl/dec_timer.sv
// Loadable down-counting timer with optional auto-reload.
// Ports:
//   CLK, RST (async, active-high)
//   LD_VAL/LD_RDY/LD_DATA - load handshake; LD_DATA is start and reload value
//   EN      - count tick, one decrement per cycle while counting
//   RELOAD  - on terminal count: 1 = restart from reload value, 0 = stop
//   ABORT   - stop a running count, keep Q, no terminal pulse
//   Q       - registered count value
//   BUSY    - counting; TC - registered terminal-count pulse
module dec_timer
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = lau_pkg::FAST
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_VAL,
    output logic             LD_RDY,
    input  logic [width-1:0] LD_DATA,
    input  logic             EN,
    input  logic             RELOAD,
    input  logic             ABORT,
    output logic [width-1:0] Q,
    output logic             BUSY,
    output logic             TC
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] rv_q, rv_d;
    logic             tc_q, tc_d;

    logic [width-1:0] dec_s;
    logic             dec_co;
    logic             dec_zero;

    DecC #(
        .width(width),
        .speed(speed)
    ) u_dec (
        .A (q_q),
        .CI(EN),
        .S (dec_s),
        .CO(dec_co)
    );

    // Q >= 1 throughout RUN, so the borrow never fires there; folding it in
    // keeps a hypothetical wrap from ever being mistaken for a terminal count.
    assign dec_zero = ~(|dec_s) & ~dec_co;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rv_d    = rv_q;
        tc_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // LD_RDY is high in IDLE, so LD_VAL alone completes the handshake.
                if (LD_VAL) begin
                    q_d  = LD_DATA;
                    rv_d = LD_DATA;
                    if (LD_DATA == '0) begin
                        tc_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (EN) begin
                    if (dec_zero) begin
                        tc_d = 1'b1;
                        if (RELOAD) begin
                            // Skip the zero value so the period is exactly rv ticks.
                            q_d = rv_q;
                        end else begin
                            q_d     = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        q_d = dec_s;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            q_q     <= '0;
            rv_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rv_q    <= rv_d;
            tc_q    <= tc_d;
        end
    end

    assign Q      = q_q;
    assign TC     = tc_q;
    assign BUSY   = (state_q == RUN);
    assign LD_RDY = (state_q == IDLE);

endmodule
